rsa_seq_ctrl: RTL and testbench
===============================

Name: rsa_seq_ctrl

Overview:
- Sequencer for the X×N×Y systolic MAC array and its input/output FIFOs.
- Accepts matrix A (X×N, on Xin) and matrix B (N×Y, on Yin) through valid/ready handshakes and steers each word into its west or north input FIFO.
- Issues skewed FIFO read enables and cal_en/cal_done during compute, then drains the per-row output FIFOs over an out_val/out_rdy handshake.
- Sits beside the array top level and replaces hand-sequenced enables.

Parameters:
- X, 3, array rows; westin and out FIFO count.
- N, 3, inner dimension; words per input FIFO.
- Y, 3, array columns; northin FIFO count.
- PE_LAT, 1, extra drain cycles for PE pipeline latency.
- ADDR_WIDTH, 2, FIFO address width; DEPTH = N.

Ports:
- clk  in  1  clock, rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- Xin_val  in  1  A word valid.
- Xin_rdy  out  1  A word accepted when Xin_val & Xin_rdy.
- Yin_val  in  1  B word valid.
- Yin_rdy  out  1  B word accepted when Yin_val & Yin_rdy.
- westin_wr_en  out  X  one-hot write enable, west FIFOs.
- northin_wr_en  out  Y  one-hot write enable, north FIFOs.
- westin_rd_en  out  X  skewed read enables, west FIFOs.
- northin_rd_en  out  Y  skewed read enables, north FIFOs.
- cal_en  out  1  compute enable into PE(1,1).
- cal_done  out  1  end-of-accumulation pulse into PE(1,1).
- out_rdy  in  1  consumer ready.
- out_val  out  1  result word available.
- out_rd_en  out  X  one-hot read enable, output FIFOs.
- done  out  1  one-cycle pulse after the last result word.

Behaviour:
- Reset (sys_rst=0, asynchronous): state=LOAD; all counters 0; every output 0.
- Xin_rdy and Yin_rdy rise on the first clk edge after reset release.
- States:
  - LOAD→CAL when both load counters are complete and the final wr_en cycle has been issued.
  - CAL→OUT when cycle counter c reaches N+X+Y-2+PE_LAT.
  - OUT→LOAD after X*Y words are read; done pulses on that transition.
- LOAD:
  - Xin_rdy=1 while xcnt<X*N. Yin_rdy=1 while ycnt<N*Y. The two streams are independent and complete in any order.
  - Handshake k on Xin in cycle t → westin_wr_en[k/N+1]=1 in cycle t+1 only (registered, matches the 1-cycle input data register). Yin: northin_wr_en[k/N+1] likewise.
  - A is row-major; B is column-major.
  - Val with rdy low is ignored. Both rdy are 0 in CAL and OUT.
- CAL (c = 0 at state entry):
  - westin_rd_en[i]=1 for c in [i-1, i+N-2].
  - northin_rd_en[j]=1 for c in [j-1, j+N-2].
  - cal_en=1 for c in [0, N-1]. cal_done=1 at c=N only.
  - All enables are registered decodes of c (glitch-free).
- OUT:
  - Row r = 1..X, Y words per row, rows in ascending order.
  - out_val=1 while words remain.
  - out_rd_en[r] = out_val & out_rdy (combinational). Data appears on the array output one cycle later.
  - out_rdy low stalls with no counter change.
- Widths: counters sized by clog2 of their max value + 1. No wrap inside a phase; every counter clears on state exit.
- Reset mid-operation: all enables drop immediately; partial FIFO contents are the datapath's responsibility (it receives the same reset).

Decomposition:
- Shared defs include (rsa_defs): state encodings LOAD/CAL/OUT, CAL_LEN = N+X+Y-2+PE_LAT, clog2 function.
- Sub-module rsa_skew_gen: takes c, emits the registered westin_rd_en, northin_rd_en, cal_en and cal_done decodes. Parameterised by X, Y, N.

Test Plan (X=N=Y=3, PE_LAT=1):
- Reset: hold sys_rst=0 → all outputs 0. Release → next edge Xin_rdy=Yin_rdy=1, no wr_en.
- Back-to-back load: 9 Xin handshakes cycles 0-8 → westin_wr_en = 001 in cycles 1-3, 010 in 4-6, 100 in 7-9; Xin_rdy=0 from cycle 9. Yin same pattern on northin_wr_en.
- Unbalanced load: Yin finishes at cycle 8, Xin has random gaps and finishes at cycle 20 → Yin_rdy=0 from 9, CAL entered at cycle 22, no extra wr_en.
- CAL skew: westin_rd_en[1] high c0-2, [2] c1-3, [3] c2-4 (north identical). cal_en high c0-2, cal_done at c3 only. OUT entered after c=8.
- OUT with out_rdy toggling 1,0,1,0 → exactly 9 out_rd_en pulses, one-hot in order 001×3, 010×3, 100×3. done pulses once; Xin_rdy returns to 1.
- Assert sys_rst at c=4 → all rd_en and cal_en fall without a clock edge. After release, state=LOAD and a full transaction completes correctly.

Source files
------------

// File: rtl/rsa_seq_ctrl_pkg.sv
// Shared definitions for the systolic-array sequencer: phase encodings and sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rsa_seq_ctrl_pkg;

    // Controller phases: fill input FIFOs, run the array, drain the output FIFOs.
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CAL  = 2'd1,
        ST_OUT  = 2'd2
    } rsa_state_t;

    // Bits needed to hold values 0..v-1 (never less than one bit).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Last value of the compute cycle counter: the final operand reaches PE(X,Y)
    // after N+X+Y-2 cycles, plus the PE pipeline depth.
    function automatic int cal_len(input int x, input int n, input int y, input int pe_lat);
        return n + x + y - 2 + pe_lat;
    endfunction

endpackage

// File: rtl/rsa_skew_gen.sv
// Registered decode of the compute cycle counter into skewed FIFO reads and PE(1,1) controls.
// Latency: outputs reflect the counter value presented one cycle earlier (feed it the next value).
// Backpressure: none; the array runs unconditionally once started.
//
// Ports: clk/rst_n (async active-low), cal_act (next cycle is a compute cycle),
//        c (next compute cycle index), westin_rd_en[X], northin_rd_en[Y], cal_en, cal_done.
module rsa_skew_gen #(
    parameter int X  = 3,
    parameter int Y  = 3,
    parameter int N  = 3,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cal_act,
    input  logic [CW-1:0] c,
    output logic [X-1:0]  westin_rd_en,
    output logic [Y-1:0]  northin_rd_en,
    output logic          cal_en,
    output logic          cal_done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            westin_rd_en  <= '0;
            northin_rd_en <= '0;
            cal_en        <= 1'b0;
            cal_done      <= 1'b0;
        end else begin
            // Row/column k (0-based) starts k cycles late and streams N words.
            for (int i = 0; i < X; i++) begin
                westin_rd_en[i] <= cal_act && (int'(c) >= i) && (int'(c) <= i + N - 1);
            end
            for (int j = 0; j < Y; j++) begin
                northin_rd_en[j] <= cal_act && (int'(c) >= j) && (int'(c) <= j + N - 1);
            end
            cal_en   <= cal_act && (int'(c) <= N - 1);
            cal_done <= cal_act && (int'(c) == N);
        end
    end

endmodule

// File: rtl/rsa_seq_ctrl.sv
// Sequencer for the XxNxY systolic MAC array: loads A/B into input FIFOs, runs the skewed compute, drains results.
// Latency: wr_en one cycle after each input handshake; compute lasts N+X+Y-1+PE_LAT cycles; out_rd_en is combinational.
// Backpressure: Xin_rdy/Yin_rdy drop once each matrix is complete; out_rdy low stalls the drain with no state change.
//
// Ports: clk, sys_rst (async active-low); Xin_val/Xin_rdy, Yin_val/Yin_rdy input handshakes;
//        westin_wr_en[X], northin_wr_en[Y] one-hot FIFO writes; westin_rd_en[X], northin_rd_en[Y] skewed reads;
//        cal_en/cal_done into PE(1,1); out_val/out_rdy/out_rd_en[X] result drain; done pulse after the last word.
module rsa_seq_ctrl
    import rsa_seq_ctrl_pkg::*;
#(
    parameter int X          = 3,
    parameter int N          = 3,
    parameter int Y          = 3,
    parameter int PE_LAT     = 1,
    parameter int ADDR_WIDTH = 2
) (
    input  logic         clk,
    input  logic         sys_rst,
    input  logic         Xin_val,
    output logic         Xin_rdy,
    input  logic         Yin_val,
    output logic         Yin_rdy,
    output logic [X-1:0] westin_wr_en,
    output logic [Y-1:0] northin_wr_en,
    output logic [X-1:0] westin_rd_en,
    output logic [Y-1:0] northin_rd_en,
    output logic         cal_en,
    output logic         cal_done,
    input  logic         out_rdy,
    output logic         out_val,
    output logic [X-1:0] out_rd_en,
    output logic         done
);

    localparam int XN      = X * N;
    localparam int NY      = N * Y;
    localparam int CAL_LEN = cal_len(X, N, Y, PE_LAT);
    localparam int XCW     = clog2(XN + 1);
    localparam int YCW     = clog2(NY + 1);
    localparam int CW      = clog2(CAL_LEN + 1);
    localparam int XIW     = clog2(X + 1);
    localparam int YIW     = clog2(Y + 1);
    localparam int RW      = clog2(X);
    localparam int CLW     = clog2(Y);

    rsa_state_t             state;
    logic [XCW-1:0]         xcnt;
    logic [YCW-1:0]         ycnt;
    logic [XIW-1:0]         xidx;       // west FIFO currently being filled
    logic [YIW-1:0]         yidx;       // north FIFO currently being filled
    logic [ADDR_WIDTH-1:0]  xpos;       // word slot within that FIFO
    logic [ADDR_WIDTH-1:0]  ypos;
    logic [CW-1:0]          c;
    logic [RW-1:0]          orow;
    logic [CLW-1:0]         ocol;

    logic                   x_hs;
    logic                   y_hs;
    logic                   load_done;
    logic                   cal_last;
    logic                   out_hs;
    logic                   out_last;
    logic                   cal_act_nxt;
    logic [CW-1:0]          c_nxt;

    always_comb begin
        x_hs      = Xin_val & Xin_rdy;
        y_hs      = Yin_val & Yin_rdy;
        // Counters reach full on the edge of the last handshake, which is the same
        // edge that raises the final wr_en, so leaving here keeps that write intact.
        load_done = (state == ST_LOAD) && (xcnt == XCW'(XN)) && (ycnt == YCW'(NY));
        cal_last  = (state == ST_CAL) && (c == CW'(CAL_LEN));
        out_val   = (state == ST_OUT);
        out_hs    = out_val & out_rdy;
        out_last  = out_hs && (orow == RW'(X - 1)) && (ocol == CLW'(Y - 1));

        // The skew decoder registers its inputs, so hand it next-cycle values.
        c_nxt       = '0;
        cal_act_nxt = load_done;
        if ((state == ST_CAL) && !cal_last) begin
            c_nxt       = c + CW'(1);
            cal_act_nxt = 1'b1;
        end

        out_rd_en = '0;
        if (out_hs) begin
            out_rd_en = X'(1) << orow;
        end
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state         <= ST_LOAD;
            xcnt          <= '0;
            ycnt          <= '0;
            xidx          <= '0;
            yidx          <= '0;
            xpos          <= '0;
            ypos          <= '0;
            c             <= '0;
            orow          <= '0;
            ocol          <= '0;
            Xin_rdy       <= 1'b0;
            Yin_rdy       <= 1'b0;
            westin_wr_en  <= '0;
            northin_wr_en <= '0;
            done          <= 1'b0;
        end else begin
            c             <= c_nxt;
            done          <= 1'b0;
            westin_wr_en  <= '0;
            northin_wr_en <= '0;
            case (state)
                ST_LOAD: begin
                    Xin_rdy <= (xcnt + XCW'(x_hs)) < XCW'(XN);
                    Yin_rdy <= (ycnt + YCW'(y_hs)) < YCW'(NY);
                    if (x_hs) begin
                        westin_wr_en <= X'(1) << xidx;
                        xcnt         <= xcnt + XCW'(1);
                        if (xpos == ADDR_WIDTH'(N - 1)) begin
                            xpos <= '0;
                            xidx <= xidx + XIW'(1);
                        end else begin
                            xpos <= xpos + ADDR_WIDTH'(1);
                        end
                    end
                    if (y_hs) begin
                        northin_wr_en <= Y'(1) << yidx;
                        ycnt          <= ycnt + YCW'(1);
                        if (ypos == ADDR_WIDTH'(N - 1)) begin
                            ypos <= '0;
                            yidx <= yidx + YIW'(1);
                        end else begin
                            ypos <= ypos + ADDR_WIDTH'(1);
                        end
                    end
                    if (load_done) begin
                        state <= ST_CAL;
                        xcnt  <= '0;
                        ycnt  <= '0;
                        xidx  <= '0;
                        yidx  <= '0;
                    end
                end
                ST_CAL: begin
                    if (cal_last) begin
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_hs) begin
                        if (ocol == CLW'(Y - 1)) begin
                            ocol <= '0;
                            orow <= orow + RW'(1);
                        end else begin
                            ocol <= ocol + CLW'(1);
                        end
                        if (out_last) begin
                            state   <= ST_LOAD;
                            orow    <= '0;
                            ocol    <= '0;
                            done    <= 1'b1;
                            Xin_rdy <= 1'b1;
                            Yin_rdy <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    rsa_skew_gen #(
        .X  (X),
        .Y  (Y),
        .N  (N),
        .CW (CW)
    ) u_skew (
        .clk           (clk),
        .rst_n         (sys_rst),
        .cal_act       (cal_act_nxt),
        .c             (c_nxt),
        .westin_rd_en  (westin_rd_en),
        .northin_rd_en (northin_rd_en),
        .cal_en        (cal_en),
        .cal_done      (cal_done)
    );

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Directed bench for rsa_seq_ctrl with X=N=Y=3, PE_LAT=1.
// Cycle t spans posedge t .. posedge t+1; inputs change and outputs are sampled on the negedge inside it.
// Each scenario task leaves time positioned just after the negedge of the first cycle of the next scenario.
module tb_rsa_seq_ctrl;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       Xin_val;
    logic       Xin_rdy;
    logic       Yin_val;
    logic       Yin_rdy;
    logic [2:0] westin_wr_en;
    logic [2:0] northin_wr_en;
    logic [2:0] westin_rd_en;
    logic [2:0] northin_rd_en;
    logic       cal_en;
    logic       cal_done;
    logic       out_rdy;
    logic       out_val;
    logic [2:0] out_rd_en;
    logic       done;

    logic [20:0] outs_all;
    int          n_chk  = 0;
    int          n_fail = 0;

    // Expected skewed read enables for c = 0..8 (west and north identical).
    localparam logic [2:0] SKEW_EXP [9] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100,
                                            3'b000, 3'b000, 3'b000, 3'b000};
    localparam logic [8:0] CAL_EN_TAB   = 9'b000000111;  // bit c
    localparam logic [8:0] CAL_DONE_TAB = 9'b000001000;

    assign outs_all = {Xin_rdy, Yin_rdy, westin_wr_en, northin_wr_en, westin_rd_en,
                       northin_rd_en, cal_en, cal_done, out_val, out_rd_en, done};

    always #5 clk = ~clk;

    rsa_seq_ctrl #(
        .X          (3),
        .N          (3),
        .Y          (3),
        .PE_LAT     (1),
        .ADDR_WIDTH (2)
    ) dut (
        .clk           (clk),
        .sys_rst       (sys_rst),
        .Xin_val       (Xin_val),
        .Xin_rdy       (Xin_rdy),
        .Yin_val       (Yin_val),
        .Yin_rdy       (Yin_rdy),
        .westin_wr_en  (westin_wr_en),
        .northin_wr_en (northin_wr_en),
        .westin_rd_en  (westin_rd_en),
        .northin_rd_en (northin_rd_en),
        .cal_en        (cal_en),
        .cal_done      (cal_done),
        .out_rdy       (out_rdy),
        .out_val       (out_val),
        .out_rd_en     (out_rd_en),
        .done          (done)
    );

    task automatic test_reset();
        sys_rst = 1'b0;
        Xin_val = 1'b1;
        Yin_val = 1'b1;
        out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (outs_all !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want all zero", outs_all);
        end
        Xin_val = 1'b0;
        Yin_val = 1'b0;
        out_rdy = 1'b0;
        sys_rst = 1'b1;
        #1;
        n_chk++;
        if ({Xin_rdy, Yin_rdy} !== 2'b00) begin
            n_fail++;
            $display("FAIL release_no_edge_rdy: got %b want 00", {Xin_rdy, Yin_rdy});
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({Xin_rdy, Yin_rdy} !== 2'b11) begin
            n_fail++;
            $display("FAIL first_edge_rdy: got %b want 11", {Xin_rdy, Yin_rdy});
        end
        n_chk++;
        if ({westin_wr_en, northin_wr_en} !== 6'd0) begin
            n_fail++;
            $display("FAIL first_edge_wr_en: got %b want 000000", {westin_wr_en, northin_wr_en});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ew;
        for (int t = 0; t <= 9; t++) begin
            Xin_val = 1'b1;   // still high at t=9 with rdy low: must be ignored
            Yin_val = 1'b1;
            #1;
            ew = (t >= 1 && t <= 3) ? 3'b001 :
                 (t >= 4 && t <= 6) ? 3'b010 :
                 (t >= 7)           ? 3'b100 : 3'b000;
            n_chk++;
            if (westin_wr_en !== ew) begin
                n_fail++;
                $display("FAIL b2b_west_wr t=%0d: got %b want %b", t, westin_wr_en, ew);
            end
            n_chk++;
            if (northin_wr_en !== ew) begin
                n_fail++;
                $display("FAIL b2b_north_wr t=%0d: got %b want %b", t, northin_wr_en, ew);
            end
            n_chk++;
            if ({Xin_rdy, Yin_rdy} !== ((t < 9) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL b2b_rdy t=%0d: got %b want %b", t, {Xin_rdy, Yin_rdy},
                         (t < 9) ? 2'b11 : 2'b00);
            end
            n_chk++;
            if (cal_en !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_cal_en t=%0d: got %b want 0", t, cal_en);
            end
            @(negedge clk);
        end
        Xin_val = 1'b0;
        Yin_val = 1'b0;
    endtask

    task automatic test_cal_skew();
        for (int c = 0; c <= 8; c++) begin
            #1;
            n_chk++;
            if (westin_rd_en !== SKEW_EXP[c]) begin
                n_fail++;
                $display("FAIL skew_west c=%0d: got %b want %b", c, westin_rd_en, SKEW_EXP[c]);
            end
            n_chk++;
            if (northin_rd_en !== SKEW_EXP[c]) begin
                n_fail++;
                $display("FAIL skew_north c=%0d: got %b want %b", c, northin_rd_en, SKEW_EXP[c]);
            end
            n_chk++;
            if ({cal_en, cal_done} !== {CAL_EN_TAB[c], CAL_DONE_TAB[c]}) begin
                n_fail++;
                $display("FAIL skew_cal c=%0d: got en/done %b want %b", c, {cal_en, cal_done},
                         {CAL_EN_TAB[c], CAL_DONE_TAB[c]});
            end
            n_chk++;
            if ({out_val, Xin_rdy, Yin_rdy} !== 3'b000) begin
                n_fail++;
                $display("FAIL skew_idle c=%0d: got val/xr/yr %b want 000", c, {out_val, Xin_rdy, Yin_rdy});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_out();
        int         pulses;
        logic [2:0] er;
        pulses = 0;
        for (int k = 0; k <= 16; k++) begin
            out_rdy = ((k % 2) == 0);
            #1;
            er = 3'b001 << (k / 6);
            if ((k % 2) != 0) er = 3'b000;
            n_chk++;
            if (out_rd_en !== er) begin
                n_fail++;
                $display("FAIL out_rd_en k=%0d: got %b want %b", k, out_rd_en, er);
            end
            n_chk++;
            if ({out_val, done} !== 2'b10) begin
                n_fail++;
                $display("FAIL out_val_done k=%0d: got %b want 10", k, {out_val, done});
            end
            if (out_rd_en != 3'b000) pulses++;
            @(negedge clk);
        end
        out_rdy = 1'b0;
        #1;
        n_chk++;
        if (pulses != 9) begin
            n_fail++;
            $display("FAIL out_pulse_count: got %0d want 9", pulses);
        end
        n_chk++;
        if ({done, out_val, Xin_rdy, Yin_rdy} !== 4'b1011) begin
            n_fail++;
            $display("FAIL out_finish: got done/val/xr/yr %b want 1011", {done, out_val, Xin_rdy, Yin_rdy});
        end
    endtask

    task automatic test_unbalanced();
        int         hx [9];
        logic [2:0] ew;
        logic [2:0] en;
        hx = '{0, 2, 3, 6, 9, 10, 13, 17, 20};
        for (int t = 0; t <= 22; t++) begin
            Xin_val = (t == 21);   // t=21 arrives with rdy low
            for (int k = 0; k < 9; k++) begin
                if (hx[k] == t) Xin_val = 1'b1;
            end
            Yin_val = (t <= 12);
            #1;
            ew = 3'b000;
            for (int k = 0; k < 9; k++) begin
                if (hx[k] + 1 == t) ew = 3'b001 << (k / 3);
            end
            en = (t >= 1 && t <= 3) ? 3'b001 :
                 (t >= 4 && t <= 6) ? 3'b010 :
                 (t >= 7 && t <= 9) ? 3'b100 : 3'b000;
            n_chk++;
            if (westin_wr_en !== ew) begin
                n_fail++;
                $display("FAIL unbal_west_wr t=%0d: got %b want %b", t, westin_wr_en, ew);
            end
            n_chk++;
            if (northin_wr_en !== en) begin
                n_fail++;
                $display("FAIL unbal_north_wr t=%0d: got %b want %b", t, northin_wr_en, en);
            end
            n_chk++;
            if ({Xin_rdy, Yin_rdy} !== {(t <= 20), (t <= 8)}) begin
                n_fail++;
                $display("FAIL unbal_rdy t=%0d: got %b want %b", t, {Xin_rdy, Yin_rdy}, {(t <= 20), (t <= 8)});
            end
            n_chk++;
            if ({cal_en, done} !== {(t == 22), (t == 0)}) begin
                n_fail++;
                $display("FAIL unbal_cal_done t=%0d: got en/done %b want %b", t, {cal_en, done},
                         {(t == 22), (t == 0)});
            end
            if (t < 22) @(negedge clk);
        end
        Xin_val = 1'b0;
        Yin_val = 1'b0;
    endtask

    task automatic test_reset_mid();
        repeat (4) @(negedge clk);
        #1;
        n_chk++;
        if ({westin_rd_en, northin_rd_en} !== 6'b100100) begin
            n_fail++;
            $display("FAIL mid_pre_rd_en: got %b want 100100", {westin_rd_en, northin_rd_en});
        end
        #1;
        sys_rst = 1'b0;
        #1;
        n_chk++;
        if (outs_all !== 21'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outs: got %b want all zero", outs_all);
        end
        @(negedge clk);
        sys_rst = 1'b1;
        #1;
        n_chk++;
        if ({Xin_rdy, Yin_rdy, cal_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_release: got %b want 000", {Xin_rdy, Yin_rdy, cal_en});
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({Xin_rdy, Yin_rdy, westin_rd_en} !== 5'b11000) begin
            n_fail++;
            $display("FAIL mid_back_to_load: got %b want 11000", {Xin_rdy, Yin_rdy, westin_rd_en});
        end
    endtask

    task automatic test_idle_after();
        @(negedge clk);
        #1;
        n_chk++;
        if ({done, Xin_rdy, Yin_rdy, westin_wr_en} !== 6'b011000) begin
            n_fail++;
            $display("FAIL idle_after: got done/xr/yr/wwr %b want 011000",
                     {done, Xin_rdy, Yin_rdy, westin_wr_en});
        end
    endtask

    initial begin
        sys_rst = 1'b0;
        Xin_val = 1'b0;
        Yin_val = 1'b0;
        out_rdy = 1'b0;
        test_reset();
        test_back_to_back();
        test_cal_skew();
        test_out();
        test_unbalanced();
        test_reset_mid();
        test_back_to_back();
        test_cal_skew();
        test_out();
        test_idle_after();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
